// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared state encoding, W-vector control bit map and default widths
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_SHIFT    = 2;
  localparam int CTRL_MFHI     = 3;
  localparam int CTRL_MFLO     = 4;
  localparam int CTRL_HILO_WE  = 5;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DEST_W = 5;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
// ============================================================================
// Module   : pipe_sat_cnt
// Purpose  : 32-bit event counter that sticks at all-ones
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready stage register with 2-entry skid, flush and ctrl gating
//            Optional perf counters under PIPE_STAGE_PERF_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W            = DEF_DATA_W,
  parameter int CTRL_W            = DEF_CTRL_W,
  parameter int DEST_W            = DEF_DEST_W,
  parameter int CLR_DATA_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [DEST_W-1:0] m_dest_q, m_dest_d, s_dest_q, s_dest_d;
  logic              acc;
  logic              drn;

  // in_ready depends on state alone so upstream never sees a combinational loop
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    m_dest_d = m_dest_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    s_dest_d = s_dest_q;
    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if (CLR_DATA_ON_FLUSH != 0) begin
        m_data_d = '0;
        m_dest_d = '0;
        s_data_d = '0;
        s_dest_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            m_dest_d = in_dest;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            m_dest_d = in_dest;
          end else if (acc) begin
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
            s_dest_d = in_dest;
            state_d  = TWO;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            m_dest_d = s_dest_q;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      m_dest_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      s_dest_q <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      m_dest_q <= m_dest_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      s_dest_q <= s_dest_d;
    end
  end

  // Gating keeps a bubble from ever asserting RegWrite or any other control bit
  assign out_ctrl = m_ctrl_q & {CTRL_W{out_valid}};
  assign out_data = m_data_q;
  assign out_dest = m_dest_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~out_valid),
    .cnt (bubble_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed scoreboard bench for pipe_stage_skid (perf part under
//            PIPE_STAGE_PERF_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_dest;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic [4:0]  dest;
  } beat_t;

  beat_t sb_q[$];

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_dest  (out_dest)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every downstream transfer, checks gating and hold stability
  logic        hold_v = 1'b0;
  beat_t       prev;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_ctrl", out_ctrl, prev.ctrl);
        chk("hold_data", out_data, prev.data);
        chk("hold_dest", out_dest, prev.dest);
      end
      if (!out_valid) chk("bubble_ctrl", out_ctrl, 8'h00);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h expected none", out_data);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          chk("beat_ctrl", out_ctrl, e.ctrl);
          chk("beat_data", out_data, e.data);
          chk("beat_dest", out_dest, e.dest);
        end
      end
      if (flush) sb_q.delete();
      hold_v = out_valid && !out_ready && !flush;
      prev = '{ctrl: out_ctrl, data: out_data, dest: out_dest};
    end
  end

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_ctrl  = 8'h00;
  endtask

  // One cycle of stimulus; exp_rdy/exp_ov are the hand-derived values seen before the edge
  task automatic step(input logic v, input logic [7:0] c, input logic [63:0] d,
                      input logic ordy, input logic fl, input logic exp_rdy, input logic exp_ov);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    in_dest   = d[4:0];
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (v && exp_rdy && !fl) sb_q.push_back('{ctrl: c, data: d, dest: d[4:0]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 8'h00);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_dest", out_dest, 5'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, 8'h01, 64'(i), 1'b1, 1'b0, 1'b1, (i > 1));
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure fills the skid
    step(1'b1, 8'h03, 64'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h05, 64'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_hold_data", out_data, 64'h11);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0);

    // Flush while TWO with C offered
    step(1'b1, 8'h21, 64'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h21, 64'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h21, 64'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_out_ctrl", out_ctrl, 8'h00);
    chk("flush_keeps_data", out_data, 64'h44);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0);

    // Flush in ONE: head transfers, offered beat dropped although in_ready=1
    step(1'b1, 8'h09, 64'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h09, 64'h88, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0);

    // Bubble gating with RegWrite set on the idle input
    for (int i = 0; i < 4; i++) step(1'b0, 8'h01 << CTRL_REGWRITE, 64'hDEAD, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation discards the held beat
    step(1'b1, 8'h01, 64'h66, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_data", out_data, 64'h0);

`ifdef PIPE_STAGE_PERF_EN
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h01, 64'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("perf_bubble", bubble_cnt, 64'd10);
    chk("perf_stall", stall_cnt, 64'd3);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("perf_bubble_flush", bubble_cnt, 64'd10);
    chk("perf_stall_flush", stall_cnt, 64'd3);
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised valid/ready pipeline stage register. It replaces the fixed-field enable-only inter-stage registers (EX/MEM, MEM/WB) with one generic block.
- Carries a control vector, a data payload and a destination register index.
- Adds backpressure through a two-entry skid buffer, a synchronous flush that inserts bubbles, and control gating so a bubble can never assert RegWrite.

Parameters:
- DATA_W, 64, payload width in bits (e.g. ALU result, shifter result, memory data, concatenated).
- CTRL_W, 8, control vector width; bit indices come from the shared package.
- DEST_W, 5, destination register index width.
- CLR_DATA_ON_FLUSH, 0, when 1, flush also zeroes the data and dest registers; when 0, only valid and ctrl are cleared.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream payload
- in_dest  in  DEST_W  upstream destination index
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control, forced to 0 when out_valid=0
- out_data  out  DATA_W  payload
- out_dest  out  DEST_W  destination index

Behaviour:
- Storage: main register (m_*) drives the outputs. Skid register (s_*) holds one extra beat. Every register updates only on posedge clk.
- States:
  - EMPTY: m invalid, s invalid.
  - ONE: m valid, s invalid.
  - TWO: m valid, s valid.
- Derived signals:
  - in_ready = (state != TWO). It is combinational from state only and never depends on in_valid or out_ready.
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
- Transitions (when flush=0):
  - EMPTY: if acc, load m and go to ONE.
  - ONE:
    - acc & drn: load m, stay ONE.
    - acc & !drn: load s, go to TWO.
    - !acc & drn: go to EMPTY.
    - otherwise: hold.
  - TWO: if drn, move s into m and go to ONE; otherwise hold. No accept is possible because in_ready=0.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1. Throughput is one beat per cycle while out_ready=1.
- Ordering: beats leave in acceptance order. No beat is ever duplicated or lost except by flush.
- out_valid = m valid. out_ctrl = m_ctrl & {CTRL_W{out_valid}}. out_data and out_dest are the m contents regardless of valid.
- Flush:
  - Next state is EMPTY and both valid bits clear. m_ctrl and s_ctrl go to 0.
  - A beat offered in the same cycle is dropped, even though in_ready may read 1.
  - Flush wins over acc and drn. A beat shown with out_valid=1 in the flush cycle counts as transferred if out_ready=1.
- Reset: rst has priority over flush. After the reset edge:
  - state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, out_dest=0, in_ready=1.
  - All s registers are 0.
  - Reset asserted mid-operation discards all held beats.
- Hold: while out_valid=1 and out_ready=0, out_ctrl, out_data and out_dest must stay stable.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds two outputs, stall_cnt [31:0] and bubble_cnt [31:0].
  - stall_cnt increments on cycles with out_valid & !out_ready.
  - bubble_cnt increments on cycles with !out_valid.
  - Both saturate at all-ones, are cleared by rst and are unaffected by flush.
- Not defined: the ports and logic are absent and the block behaves identically otherwise.

Decomposition:
- Package pipe_pkg holds:
  - The state enum (EMPTY, ONE, TWO).
  - Control bit indices: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_SHIFT=2, CTRL_MFHI=3, CTRL_MFLO=4, CTRL_HILO_WE=5. These keep the existing W-vector mapping.
  - Default width constants.
- One sub-module, pipe_sat_cnt: a 32-bit saturating counter with inc and rst. It is instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then idle: assert rst for 2 cycles with in_valid=1, in_ctrl=8'hFF. After release: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: send data 1..8, one per cycle, with out_ready=1. out_data shows 1..8 in consecutive cycles, each one cycle after acceptance, and in_ready stays 1 throughout.
- Backpressure:
  - Send A=0x11 then B=0x22 with out_ready=0. in_ready drops to 0 after B is accepted and out_data holds 0x11.
  - Raise out_ready. Outputs are 0x11 then 0x22, and in_ready returns to 1 in the cycle after the first drain.
- Flush in TWO with in_valid=1, C=0x33: the next cycle has out_valid=0, out_ctrl=0 and in_ready=1, and C never appears.
- Bubble gating: hold in_valid=0 with in_ctrl[CTRL_REGWRITE]=1. out_ctrl[CTRL_REGWRITE] stays 0 every cycle.
- With PIPE_STAGE_PERF_EN: 10 idle cycles, then 3 stalled cycles holding one beat, give bubble_cnt=10 and stall_cnt=3. Flush leaves both unchanged.
